// File: rtl/acc_requant_if.sv
// Requantizer stream bundle: accumulator result input (credit-gated) and activation output (valid/ready).
interface acc_requant_if #(
   parameter int ACC_WIDTH = 40,
   parameter int BIAS_DW   = 32,
   parameter int OUT_DW    = 16,
   parameter int SHIFT_W   = 6
);
   logic signed [ACC_WIDTH-1:0] acc_i;
   logic                        acc_vld_i;
   logic                        acc_rdy_o;
   logic signed [BIAS_DW-1:0]   bias_i;
   logic [SHIFT_W-1:0]          shift_i;
   logic                        relu_en_i;
   logic signed [OUT_DW-1:0]    dout_o;
   logic                        dout_vld_o;
   logic                        dout_rdy_i;

   modport master (
      output acc_i, acc_vld_i, bias_i, shift_i, relu_en_i, dout_rdy_i,
      input  acc_rdy_o, dout_o, dout_vld_o
   );

   modport slave (
      input  acc_i, acc_vld_i, bias_i, shift_i, relu_en_i, dout_rdy_i,
      output acc_rdy_o, dout_o, dout_vld_o
   );
endinterface

// File: rtl/acc_requant.sv
// Bias add, round-half-up shift, optional ReLU and saturation; 3 register stages into a show-ahead FIFO.
// Output valid 4 cycles after accept; acc_rdy_o is a credit from registered occupancy, so the FIFO never overflows.
module acc_requant #(
   parameter int ACC_WIDTH  = 40,
   parameter int BIAS_DW    = 32,
   parameter int OUT_DW     = 16,
   parameter int SHIFT_W    = 6,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   acc_requant_if.slave  bus,
   output logic          err_drop_o,
   output logic [15:0]   sat_cnt_o
);
   localparam int W1 = ACC_WIDTH + 1;
   localparam int W2 = ACC_WIDTH + 2;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int IW = CW + 1;
   localparam logic signed [W2-1:0] OUT_MAX = W2'(2**(OUT_DW-1) - 1);
   localparam logic signed [W2-1:0] OUT_MIN = ~OUT_MAX;

   logic                     accept;
   logic signed [W1-1:0]     s1_d, s1_q;
   logic [SHIFT_W-1:0]       sh1_q;
   logic                     relu1_q, relu2_q;
   logic signed [W2-1:0]     s1x, rnd, s2_d, s2_q;
   logic signed [OUT_DW-1:0] o3_d, o3_q;
   logic                     sat3_d, sat3_q;
   logic                     v1, v2, v3;

   logic [OUT_DW-1:0]        mem [FIFO_DEPTH];
   logic [PW-1:0]            wr_ptr, rd_ptr;
   logic [CW-1:0]            count;
   logic                     push, pop;
   logic [IW-1:0]            inflight;

   assign inflight      = IW'(count) + IW'(v1) + IW'(v2) + IW'(v3);
   assign bus.acc_rdy_o = inflight < IW'(FIFO_DEPTH);
   assign accept        = bus.acc_vld_i & bus.acc_rdy_o;

   assign s1_d = W1'($signed(bus.acc_i)) + W1'($signed(bus.bias_i));

   always_comb begin
      s1x  = W2'(s1_q);
      rnd  = '0;
      s2_d = s1x;
      if (sh1_q != '0) begin
         rnd  = W2'(1) << (sh1_q - SHIFT_W'(1));
         s2_d = (s1x + rnd) >>> sh1_q;
      end
   end

   // A ReLU clamp wins over clipping and is not counted as a saturation.
   always_comb begin
      o3_d   = s2_q[OUT_DW-1:0];
      sat3_d = 1'b0;
      if (relu2_q && s2_q[W2-1]) begin
         o3_d = '0;
      end else if (s2_q > OUT_MAX) begin
         o3_d   = OUT_MAX[OUT_DW-1:0];
         sat3_d = 1'b1;
      end else if (s2_q < OUT_MIN) begin
         o3_d   = OUT_MIN[OUT_DW-1:0];
         sat3_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      s1_q    <= s1_d;
      sh1_q   <= bus.shift_i;
      relu1_q <= bus.relu_en_i;
      s2_q    <= s2_d;
      relu2_q <= relu1_q;
      o3_q    <= o3_d;
      sat3_q  <= sat3_d;
      if (push) mem[wr_ptr] <= o3_q;
   end

   assign push = v3;
   assign pop  = (count != '0) & bus.dout_rdy_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1         <= 1'b0;
         v2         <= 1'b0;
         v3         <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         err_drop_o <= 1'b0;
         sat_cnt_o  <= '0;
      end else begin
         v1 <= accept;
         v2 <= v1;
         v3 <= v2;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (bus.acc_vld_i && !bus.acc_rdy_o) err_drop_o <= 1'b1;
         if (push && sat3_q && sat_cnt_o != 16'hFFFF) sat_cnt_o <= sat_cnt_o + 16'd1;
      end
   end

   assign bus.dout_vld_o = count != '0;
   assign bus.dout_o     = bus.dout_vld_o ? $signed(mem[rd_ptr]) : '0;
endmodule

// File: tb/tb_acc_requant.sv
// Directed bench for acc_requant: stimulus pushes hand-computed results, a negedge monitor pops and compares.
module tb_acc_requant;
   logic        clk = 1'b0;
   logic        rst;
   logic        err_drop;
   logic [15:0] sat_cnt;
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   logic signed [15:0] expq[$];
   logic        hold_vld = 1'b0;
   logic signed [15:0] hold_dat;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   acc_requant_if bus ();

   acc_requant dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .err_drop_o (err_drop),
      .sat_cnt_o  (sat_cnt)
   );

   task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every handshake and checks the head holds while stalled.
   always @(negedge clk) begin
      if (rst) begin
         hold_vld = 1'b0;
      end else begin
         if (hold_vld && bus.dout_vld_o) check("dout_hold", bus.dout_o, hold_dat);
         if (bus.dout_vld_o && bus.dout_rdy_i) begin
            if (expq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_dout: got %0d expected no output", bus.dout_o);
            end else begin
               check("dout", bus.dout_o, expq.pop_front());
            end
            hold_vld = 1'b0;
         end else if (bus.dout_vld_o) begin
            hold_vld = 1'b1;
            hold_dat = bus.dout_o;
         end else begin
            hold_vld = 1'b0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic signed [39:0] a, input logic signed [31:0] b, input logic [5:0] sh,
                       input logic r, input logic signed [15:0] e, output logic ok);
      bus.acc_i     = a;
      bus.bias_i    = b;
      bus.shift_i   = sh;
      bus.relu_en_i = r;
      bus.acc_vld_i = 1'b1;
      ok = bus.acc_rdy_o;
      if (ok) expq.push_back(e);
      tick(1);
   endtask

   task automatic idle(input int n);
      bus.acc_vld_i = 1'b0;
      tick(n);
   endtask

   task automatic sendw(input logic signed [39:0] a, input logic signed [31:0] b, input logic [5:0] sh,
                        input logic r, input logic signed [15:0] e);
      logic ok;
      int   c = 0;
      bus.acc_vld_i = 1'b0;
      while (!bus.acc_rdy_o && c < 20) begin
         tick(1);
         c++;
      end
      send(a, b, sh, r, e, ok);
      check("accept", ok, 1);
   endtask

   task automatic drain(input string name);
      int c = 0;
      bus.acc_vld_i = 1'b0;
      while (expq.size() != 0 && c < 60) begin
         tick(1);
         c++;
      end
      check(name, expq.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1);
   end

   initial begin
      logic ok;
      logic okv [6];
      int   t0;
      rst            = 1'b1;
      bus.acc_i      = '0;
      bus.acc_vld_i  = 1'b0;
      bus.bias_i     = '0;
      bus.shift_i    = '0;
      bus.relu_en_i  = 1'b0;
      bus.dout_rdy_i = 1'b1;
      tick(2);
      rst = 1'b0;
      check("rst_dout_vld", bus.dout_vld_o, 0);
      check("rst_dout", bus.dout_o, 0);
      check("rst_acc_rdy", bus.acc_rdy_o, 1);
      check("rst_err_drop", err_drop, 0);
      check("rst_sat_cnt", sat_cnt, 0);

      // Defaults and 4-cycle latency
      send(40'sd1000, 32'sd24, 6'd4, 1'b0, 16'sd64, ok);
      check("t1_accept", ok, 1);
      bus.acc_vld_i = 1'b0;
      tick(2);
      check("t1_vld_cycle3", bus.dout_vld_o, 0);
      tick(1);
      check("t1_vld_cycle4", bus.dout_vld_o, 1);
      drain("t1_drain");

      // Rounding, ReLU and the widest shift
      sendw(-40'sd25, 32'sd0, 6'd1, 1'b0, -16'sd12);
      sendw(-40'sd25, 32'sd0, 6'd1, 1'b1, 16'sd0);
      sendw(-40'sd13, 32'sd0, 6'd1, 1'b0, -16'sd6);
      sendw(40'sd7, -32'sd2, 6'd2, 1'b0, 16'sd1);
      sendw(40'sh7F_FFFF_FFFF, 32'sh7FFF_FFFF, 6'd40, 1'b0, 16'sd1);
      drain("t2_drain");
      check("t2_sat_cnt", sat_cnt, 0);
      check("t2_err_drop", err_drop, 0);

      // Saturation both ways
      sendw(40'sd1073741824, 32'sd0, 6'd0, 1'b0, 16'sd32767);
      sendw(-40'sd1073741824, 32'sd0, 6'd0, 1'b0, -16'sd32768);
      drain("t3_drain");
      check("t3_sat_cnt", sat_cnt, 2);

      // Backpressure: only four credits
      bus.dout_rdy_i = 1'b0;
      for (int k = 0; k < 6; k++) send(40'(100 * (k + 1)), 32'sd0, 6'd0, 1'b0, 16'(100 * (k + 1)), okv[k]);
      bus.acc_vld_i = 1'b0;
      for (int k = 0; k < 6; k++) check($sformatf("t4_accept%0d", k), okv[k], (k < 4) ? 1 : 0);
      check("t4_err_drop", err_drop, 1);
      check("t4_rdy_low", bus.acc_rdy_o, 0);
      tick(3);
      check("t4_head", bus.dout_o, 100);
      bus.dout_rdy_i = 1'b1;
      drain("t4_drain");
      tick(1);
      check("t4_rdy_back", bus.acc_rdy_o, 1);

      // Sustained stream
      t0 = cyc;
      for (int k = 1; k <= 16; k++) sendw(40'(1000 * k), 32'(k), 6'd0, 1'b0, 16'(1001 * k));
      drain("t5_drain");
      total++;
      if (cyc - t0 > 26) begin
         bad++;
         $display("FAIL t5_cycles: got %0d expected <= 26", cyc - t0);
      end

      // Reset with two results in the pipeline and two in the FIFO
      bus.dout_rdy_i = 1'b0;
      for (int k = 0; k < 4; k++) sendw(40'sd1073741824, 32'sd0, 6'd0, 1'b0, 16'sd32767);
      idle(1);
      check("t6_sat_before", sat_cnt, 4);
      check("t6_err_before", err_drop, 1);
      rst = 1'b1;
      expq.delete();
      tick(1);
      rst = 1'b0;
      check("t6_dout_vld", bus.dout_vld_o, 0);
      check("t6_acc_rdy", bus.acc_rdy_o, 1);
      check("t6_sat_cnt", sat_cnt, 0);
      check("t6_err_drop", err_drop, 0);
      bus.dout_rdy_i = 1'b1;
      idle(8);
      check("t6_no_stale", bus.dout_vld_o, 0);
      check("t6_sat_after", sat_cnt, 0);
      sendw(40'sd1000, 32'sd24, 6'd4, 1'b0, 16'sd64);
      drain("t6_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
